// File: rtl/toy_loader_pkg.sv
// Shared definitions for the toy loader / sender pair: sender state encoding
// and the byte width both blocks agree on.
package toy_loader_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned GAP_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } sender_state_e;

endpackage

// File: rtl/stupid_toy_sender_if.sv
// Upstream valid/ready bus plus the loader-facing outputs of stupid_toy_sender.
// slave is the sender's view; master is the surrounding environment's view.
interface stupid_toy_sender_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data;
    logic              load_enable;
    logic              busy;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_data, in_valid,
        input  in_ready, data, load_enable, busy, count
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, data, load_enable, busy, count
    );
endinterface

// File: rtl/toy_sync_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two.
// Read data is the current head, valid whenever empty is low.
module toy_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/stupid_toy_sender.sv
// Replays buffered upstream bytes as single-cycle load_enable strobes spaced by GAP idle cycles.
// TOY_SENDER_ONESHOT_EN: send only the first byte, then park in DONE until reset.
module stupid_toy_sender
    import toy_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GAP    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    stupid_toy_sender_if.slave bus
);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
    localparam bit               NO_GAP   = (GAP == 0);

    sender_state_e       state;
    logic [GAP_W-1:0]    gap_cnt;
    logic                fifo_rst_n;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [DATA_W-1:0]   head;

`ifdef TOY_SENDER_ONESHOT_EN
    // Flush on the edge entering DONE and keep discarding while parked there.
    assign fifo_rst_n = reset_n && (state != ST_STROBE) && (state != ST_DONE);
`else
    assign fifo_rst_n = reset_n;
`endif

    assign bus.in_ready = reset_n && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign bus.busy     = (state == ST_STROBE) || (state == ST_GAP) || !empty;

    toy_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (fifo_rst_n),
        .push    (push),
        .pop     (pop),
        .wdata   (bus.in_data),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (bus.count)
    );

    // Pop decision: every pop launches a strobe on the same edge.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:   pop = !empty;
`ifdef TOY_SENDER_ONESHOT_EN
            ST_STROBE: pop = 1'b0;
`else
            ST_STROBE: pop = NO_GAP && !empty;
`endif
            ST_GAP:    pop = (gap_cnt == GAP_W'(1)) && !empty;
            default:   pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            gap_cnt         <= '0;
            bus.data        <= '0;
            bus.load_enable <= 1'b0;
        end else begin
            bus.load_enable <= pop;
            if (pop) bus.data <= head;
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_STROBE;
                end
                ST_STROBE: begin
`ifdef TOY_SENDER_ONESHOT_EN
                    state <= ST_DONE;
`else
                    if (!NO_GAP) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end else if (!pop) begin
                        state <= ST_IDLE;
                    end
`endif
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt <= GAP_W'(1)) state <= pop ? ST_STROBE : ST_IDLE;
                end
                default: state <= state;
            endcase
        end
    end
endmodule
